fwd_sel_ctrl: RTL and testbench
===============================

FWD_SEL_CTRL -- requirements
Module: fwd_sel_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: number of filter cores sharing the forwarding mux tree.
REQ-002 SHALL have parameter PIPE_DEPTH, default 1: mux tree select-to-result latency in cycles (tree height).
REQ-003 SHALL have parameter CREDITS, default 8: downstream buffer beats available after reset.
REQ-004 SHALL have derived parameter TAG_SZ = 2*ceil(log4(PADDED)), where PADDED is the smallest value >= N with PADDED mod 3 == 1; TAG_SZ is not user-set.
REQ-005 SHALL have port clk, input, 1: clock; all state changes on rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port req, input, N: core i holds a packet ready to forward.
REQ-008 SHALL have port core_last, input, N: core i's current head beat is the last beat of its packet.
REQ-009 SHALL have port credit_ret, input, 1: downstream freed one beat slot this cycle.
REQ-010 SHALL have port grant, output, N: one-hot owner of the mux tree; all zero when idle.
REQ-011 SHALL have port rd_en, output, N: pop one beat from core i; data is valid at the mux tree input in the same cycle.
REQ-012 SHALL have port sel, output, TAG_SZ: binary index of the granted core, driven to the mux tree sel input.
REQ-013 SHALL have port out_valid, output, 1: the mux tree result holds a valid beat.
REQ-014 SHALL have port out_last, output, 1: that beat is the last beat of its packet.

Function
REQ-015 SHALL implement an FSM with two states, IDLE and BUSY.
REQ-016 IDLE with req != 0 SHALL, on the next edge, load grant with the arbitration winner, load sel with its index, and enter BUSY.
REQ-017 IDLE with req == 0 SHALL hold grant = 0.
REQ-018 In BUSY, rd_en[g] SHALL equal (credit_cnt != 0) for granted core g; all other rd_en bits SHALL be 0.
REQ-019 A beat issued with core_last[g] = 1 SHALL return the FSM to IDLE on the next edge, with grant cleared; re-arbitration follows in that IDLE cycle.
REQ-020 grant and sel SHALL change only on the packet-end transition or in IDLE; they SHALL never change mid-packet, even if req[g] drops.
REQ-021 credit_cnt SHALL be a counter wide enough for CREDITS: decrement by 1 per issued beat, increment by 1 per credit_ret, unchanged when both occur in the same cycle.
REQ-022 credit_cnt SHALL never exceed CREDITS; a credit_ret at CREDITS SHALL be ignored.
REQ-023 credit_cnt SHALL never underflow; at 0, no beat SHALL issue.
REQ-024 out_valid and out_last SHALL be (|rd_en) and core_last[g] delayed by exactly PIPE_DEPTH cycles through a shift register.
REQ-025 sel SHALL be registered such that the tree's internal sel pipeline aligns each beat with its own tag, including back-to-back packets from different cores.
REQ-026 Non-power-of-3+1 N (e.g. N = 6, PADDED = 7) SHALL use the same binary encoding, since padding inputs occupy indices >= N and are never granted.

Reset
REQ-027 On rst = 1, the block SHALL set FSM to IDLE, grant = 0, rd_en = 0, sel = 0, credit_cnt = CREDITS, and clear the whole out_valid/out_last pipeline; out_valid = 0 and out_last = 0 on the cycle after rst.
REQ-028 rst asserted mid-packet SHALL abandon the packet with no further rd_en; rst has priority over every other event.

Configuration
REQ-029 With macro FWD_SEL_RR_EN defined, arbitration SHALL be round-robin: search starts at the index after the last granted core, wrapping N-1 -> 0; the last-grant pointer resets to N-1.
REQ-030 Without FWD_SEL_RR_EN, arbitration SHALL be fixed priority, with the lowest requesting index winning.

Verification
REQ-031 With N = 4, PIPE_DEPTH = 2, req = 0010, and a 3-beat packet with last on beat 3: grant = 0010, sel = 1, rd_en[1] high for 3 cycles, out_valid high in cycles +2..+4, out_last only at +4.
REQ-032 With CREDITS = 2, no credit_ret, and a 5-beat packet: exactly 2 beats issue, then rd_en = 0; one credit_ret releases exactly 1 further beat.
REQ-033 With FWD_SEL_RR_EN, req = 1111 held, and 1-beat packets: grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-034 Without FWD_SEL_RR_EN, same stimulus as REQ-033: grant stays 0001 every packet.
REQ-035 With rst pulsed on the 2nd beat of a 4-beat packet: the next cycle has grant = 0, out_valid = 0, credit_cnt = CREDITS, and no further beats.
REQ-036 With credit_cnt = CREDITS, and simultaneous issue + credit_ret at credit_cnt = 1: counter unchanged; an extra credit_ret at CREDITS is ignored.

Source files
------------

// File: rtl/fwd_sel_ctrl.sv
// +--------------------------------------------------------------------------+
// | fwd_sel_ctrl: credit-gated packet arbiter driving a shared forwarding    |
// | mux tree. Optional macro FWD_SEL_RR_EN selects round-robin arbitration.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module fwd_sel_ctrl #(
  parameter int  N          = 4,
  parameter int  PIPE_DEPTH = 1,
  parameter int  CREDITS    = 8,
  localparam int PADDED     = N + ((4 - (N % 3)) % 3),
  localparam int TAG_SZ     = 2 * (($clog2(PADDED) + 1) / 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      core_last,
  input  logic              credit_ret,
  output logic [N-1:0]      grant,
  output logic [N-1:0]      rd_en,
  output logic [TAG_SZ-1:0] sel,
  output logic              out_valid,
  output logic              out_last
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [TAG_SZ-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]  credit_cnt_q, credit_cnt_d;

  logic [N-1:0]      win_onehot;
  logic [IDX_W-1:0]  win_idx;
  logic              issue;
  logic              beat_last;

`ifdef FWD_SEL_RR_EN
  logic [IDX_W-1:0]  rr_last_q, rr_last_d;
`endif

  always_comb begin
    win_idx    = '0;
    win_onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) win_idx = IDX_W'(i);
    end
`ifdef FWD_SEL_RR_EN
    // A requester above the pointer overrides the wrapped lowest-index winner.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (IDX_W'(i) > rr_last_q)) win_idx = IDX_W'(i);
    end
`endif
    for (int i = 0; i < N; i++) begin
      win_onehot[i] = (IDX_W'(i) == win_idx);
    end
  end

  // Reset gates the pop so an abandoned packet loses no beat during rst.
  assign issue     = (state_q == BUSY) && (credit_cnt_q != '0) && !rst;
  assign rd_en     = issue ? grant_q : '0;
  assign beat_last = |(core_last & grant_q);
  assign grant     = grant_q;
  assign sel       = sel_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          grant_d = win_onehot;
          sel_d   = TAG_SZ'(win_idx);
        end
      end
      BUSY: begin
        if (issue && beat_last) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credit_cnt_d = credit_cnt_q;
    if (issue && !credit_ret) begin
      credit_cnt_d = credit_cnt_q - CNT_W'(1);
    end else if (credit_ret && !issue && (credit_cnt_q != CREDIT_MAX)) begin
      credit_cnt_d = credit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      sel_q        <= '0;
      credit_cnt_q <= CREDIT_MAX;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      sel_q        <= sel_d;
      credit_cnt_q <= credit_cnt_d;
    end
  end

`ifdef FWD_SEL_RR_EN
  always_comb begin
    rr_last_d = rr_last_q;
    if ((state_q == IDLE) && (|req)) rr_last_d = win_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= IDX_W'(N - 1);
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`endif

  generate
    if (PIPE_DEPTH == 0) begin : g_no_pipe
      assign out_valid = |rd_en;
      assign out_last  = issue & beat_last;
    end else begin : g_pipe
      logic [PIPE_DEPTH-1:0] pv_valid_q;
      logic [PIPE_DEPTH-1:0] pv_last_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          pv_valid_q <= '0;
          pv_last_q  <= '0;
        end else begin
          pv_valid_q <= (pv_valid_q << 1) | PIPE_DEPTH'(|rd_en);
          pv_last_q  <= (pv_last_q << 1) | PIPE_DEPTH'(issue & beat_last);
        end
      end

      assign out_valid = pv_valid_q[PIPE_DEPTH-1];
      assign out_last  = pv_last_q[PIPE_DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fwd_sel_ctrl.sv
// Directed bench for fwd_sel_ctrl: three instances (N=4/PD=2/CR=8, N=4/PD=1/CR=2, N=6).
`default_nettype none

module tb_fwd_sel_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] a_req, a_last, a_grant, a_rd;
  logic       a_cret, a_ov, a_ol;
  logic [1:0] a_sel;

  logic [3:0] b_req, b_last, b_grant, b_rd;
  logic       b_cret, b_ov, b_ol;
  logic [1:0] b_sel;

  logic [5:0] c_req, c_last, c_grant, c_rd;
  logic       c_cret, c_ov, c_ol;
  logic [3:0] c_sel;

  fwd_sel_ctrl #(.N(4), .PIPE_DEPTH(2), .CREDITS(8)) dut_a (
    .clk(clk), .rst(rst), .req(a_req), .core_last(a_last), .credit_ret(a_cret),
    .grant(a_grant), .rd_en(a_rd), .sel(a_sel), .out_valid(a_ov), .out_last(a_ol)
  );

  fwd_sel_ctrl #(.N(4), .PIPE_DEPTH(1), .CREDITS(2)) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .core_last(b_last), .credit_ret(b_cret),
    .grant(b_grant), .rd_en(b_rd), .sel(b_sel), .out_valid(b_ov), .out_last(b_ol)
  );

  fwd_sel_ctrl #(.N(6), .PIPE_DEPTH(1), .CREDITS(8)) dut_c (
    .clk(clk), .rst(rst), .req(c_req), .core_last(c_last), .credit_ret(c_cret),
    .grant(c_grant), .rd_en(c_rd), .sel(c_sel), .out_valid(c_ov), .out_last(c_ol)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_req = '0; a_last = '0; a_cret = 1'b0;
    b_req = '0; b_last = '0; b_cret = 1'b0;
    c_req = '0; c_last = '0; c_cret = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want %b", a_grant, 4'b0000); end
    checks++; if (a_rd !== 4'b0000) begin errors++; $display("FAIL reset_rd_en got %b want %b", a_rd, 4'b0000); end
    checks++; if (a_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", a_sel); end
    checks++; if (a_ov !== 1'b0 || a_ol !== 1'b0) begin errors++; $display("FAIL reset_out got v=%b l=%b want 0 0", a_ov, a_ol); end
    checks++; if (dut_a.credit_cnt_q !== 4'd8) begin errors++; $display("FAIL reset_credit got %0d want 8", dut_a.credit_cnt_q); end
    checks++; if (dut_b.credit_cnt_q !== 2'd2) begin errors++; $display("FAIL reset_credit_b got %0d want 2", dut_b.credit_cnt_q); end
  endtask

  task automatic test_single_packet();
    logic [3:0] exp_rd, exp_g;
    logic       exp_ov, exp_ol;
    do_reset();
    a_req = 4'b0010;
    tick();
    for (int k = 0; k < 6; k++) begin
      exp_g  = (k < 3) ? 4'b0010 : 4'b0000;
      exp_rd = (k < 3) ? 4'b0010 : 4'b0000;
      exp_ov = (k >= 2) && (k <= 4);
      exp_ol = (k == 4);
      checks++; if (a_grant !== exp_g) begin errors++; $display("FAIL pkt_grant k=%0d got %b want %b", k, a_grant, exp_g); end
      checks++; if (a_rd !== exp_rd) begin errors++; $display("FAIL pkt_rd_en k=%0d got %b want %b", k, a_rd, exp_rd); end
      checks++; if (a_ov !== exp_ov) begin errors++; $display("FAIL pkt_out_valid k=%0d got %b want %b", k, a_ov, exp_ov); end
      checks++; if (a_ol !== exp_ol) begin errors++; $display("FAIL pkt_out_last k=%0d got %b want %b", k, a_ol, exp_ol); end
      if (k < 3) begin
        checks++; if (a_sel !== 2'd1) begin errors++; $display("FAIL pkt_sel k=%0d got %0d want 1", k, a_sel); end
      end
      a_req  = 4'b0000;  // dropped mid-packet; grant must hold
      a_last = (k == 2) ? 4'b0010 : 4'b0000;
      tick();
    end
    checks++; if (dut_a.credit_cnt_q !== 4'd5) begin errors++; $display("FAIL pkt_credit got %0d want 5", dut_a.credit_cnt_q); end
  endtask

  task automatic test_credit_stall();
    logic [3:0] exp_rd;
    logic       exp_ov;
    do_reset();
    b_req = 4'b0001;
    tick();
    for (int k = 0; k < 7; k++) begin
      exp_rd = (k < 2 || k == 4) ? 4'b0001 : 4'b0000;
      exp_ov = (k == 1 || k == 2 || k == 5);
      checks++; if (b_rd !== exp_rd) begin errors++; $display("FAIL stall_rd_en k=%0d got %b want %b", k, b_rd, exp_rd); end
      checks++; if (b_grant !== 4'b0001) begin errors++; $display("FAIL stall_grant k=%0d got %b want 0001", k, b_grant); end
      checks++; if (b_ov !== exp_ov) begin errors++; $display("FAIL stall_out_valid k=%0d got %b want %b", k, b_ov, exp_ov); end
      checks++; if (b_ol !== 1'b0) begin errors++; $display("FAIL stall_out_last k=%0d got %b want 0", k, b_ol); end
      if (k == 0) begin
        checks++; if (b_sel !== 2'd0) begin errors++; $display("FAIL stall_sel got %0d want 0", b_sel); end
      end
      b_cret = (k == 3);
      tick();
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_g [5];
    logic [1:0] exp_s [5];
`ifdef FWD_SEL_RR_EN
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_s = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    do_reset();
    a_req  = 4'b1111;
    a_last = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      tick();
      checks++; if (a_grant !== exp_g[p]) begin errors++; $display("FAIL arb_grant p=%0d got %b want %b", p, a_grant, exp_g[p]); end
      checks++; if (a_sel !== exp_s[p]) begin errors++; $display("FAIL arb_sel p=%0d got %0d want %0d", p, a_sel, exp_s[p]); end
      checks++; if (a_rd !== exp_g[p]) begin errors++; $display("FAIL arb_rd_en p=%0d got %b want %b", p, a_rd, exp_g[p]); end
      tick();
      checks++; if (a_grant !== 4'b0000) begin errors++; $display("FAIL arb_idle p=%0d got %b want 0000", p, a_grant); end
    end
    a_req  = 4'b0000;
    a_last = 4'b0000;
  endtask

  task automatic test_rst_mid_packet();
    do_reset();
    a_req = 4'b0001;
    tick();
    checks++; if (a_rd !== 4'b0001) begin errors++; $display("FAIL rstmid_beat1 got %b want 0001", a_rd); end
    tick();
    a_req = 4'b0000;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    checks++; if (a_grant !== 4'b0000) begin errors++; $display("FAIL rstmid_grant got %b want 0000", a_grant); end
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", a_ov); end
    checks++; if (dut_a.credit_cnt_q !== 4'd8) begin errors++; $display("FAIL rstmid_credit got %0d want 8", dut_a.credit_cnt_q); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (a_rd !== 4'b0000 || a_ov !== 1'b0) begin errors++; $display("FAIL rstmid_quiet k=%0d got rd=%b v=%b want 0000 0", k, a_rd, a_ov); end
      tick();
    end
  endtask

  task automatic test_credit_boundary();
    do_reset();
    b_cret = 1'b1;
    tick();
    checks++; if (dut_b.credit_cnt_q !== 2'd2) begin errors++; $display("FAIL cb_ret_at_max got %0d want 2", dut_b.credit_cnt_q); end
    b_cret = 1'b0;
    b_req  = 4'b0001;
    tick();
    checks++; if (b_rd !== 4'b0001) begin errors++; $display("FAIL cb_first_beat got %b want 0001", b_rd); end
    tick();
    checks++; if (dut_b.credit_cnt_q !== 2'd1) begin errors++; $display("FAIL cb_after_beat got %0d want 1", dut_b.credit_cnt_q); end
    b_cret = 1'b1;
    tick();
    checks++; if (dut_b.credit_cnt_q !== 2'd1) begin errors++; $display("FAIL cb_issue_and_ret got %0d want 1", dut_b.credit_cnt_q); end
    checks++; if (b_rd !== 4'b0001) begin errors++; $display("FAIL cb_still_issuing got %b want 0001", b_rd); end
    b_cret = 1'b0;
    b_last = 4'b0001;
    tick();
    checks++; if (dut_b.credit_cnt_q !== 2'd0 || b_grant !== 4'b0000) begin errors++; $display("FAIL cb_end got credit=%0d grant=%b want 0 0000", dut_b.credit_cnt_q, b_grant); end
    b_req  = 4'b0000;
    b_last = 4'b0000;
    b_cret = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (dut_b.credit_cnt_q !== 2'd2) begin errors++; $display("FAIL cb_saturate got %0d want 2", dut_b.credit_cnt_q); end
    b_cret = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    a_req  = 4'b1000;
    a_last = 4'b1000;
    tick();
    checks++; if (a_grant !== 4'b1000 || a_sel !== 2'd3) begin errors++; $display("FAIL b2b_first got grant=%b sel=%0d want 1000 3", a_grant, a_sel); end
    a_req  = 4'b0010;
    a_last = 4'b1010;
    tick();
    checks++; if (a_grant !== 4'b0000) begin errors++; $display("FAIL b2b_gap got %b want 0000", a_grant); end
    tick();
    checks++; if (a_grant !== 4'b0010 || a_sel !== 2'd1) begin errors++; $display("FAIL b2b_second got grant=%b sel=%0d want 0010 1", a_grant, a_sel); end
    checks++; if (a_ov !== 1'b1 || a_ol !== 1'b1) begin errors++; $display("FAIL b2b_out1 got v=%b l=%b want 1 1", a_ov, a_ol); end
    a_req = 4'b0000;
    tick();
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL b2b_out_gap got %b want 0", a_ov); end
    tick();
    checks++; if (a_ov !== 1'b1 || a_ol !== 1'b1) begin errors++; $display("FAIL b2b_out2 got v=%b l=%b want 1 1", a_ov, a_ol); end
    a_last = 4'b0000;
  endtask

  task automatic test_n6();
    do_reset();
    c_req  = 6'b100000;
    c_last = 6'b100000;
    tick();
    checks++; if (c_grant !== 6'b100000 || c_sel !== 4'd5) begin errors++; $display("FAIL n6_first got grant=%b sel=%0d want 100000 5", c_grant, c_sel); end
    checks++; if (c_rd !== 6'b100000) begin errors++; $display("FAIL n6_rd_en got %b want 100000", c_rd); end
    c_req  = 6'b110000;
    c_last = 6'b110000;
    tick();
    checks++; if (c_ov !== 1'b1 || c_ol !== 1'b1) begin errors++; $display("FAIL n6_out got v=%b l=%b want 1 1", c_ov, c_ol); end
    tick();
    checks++; if (c_grant !== 6'b010000 || c_sel !== 4'd4) begin errors++; $display("FAIL n6_second got grant=%b sel=%0d want 010000 4", c_grant, c_sel); end
    c_req  = 6'b000000;
    tick();
    c_last = 6'b000000;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_credit_stall();
    test_arbitration();
    test_rst_mid_packet();
    test_credit_boundary();
    test_back_to_back();
    test_n6();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
